// File: rtl/data_mem_if.sv
// data_mem_if
// Groups the request/response signals of the data memory into one bundle.
// Signal names match the memory's documented port list.
//
// Requests (master -> slave):
//   read_ram        read request, sampled while the memory is ready
//   write_ram       write request, sampled while the memory is ready
//   ram_addr        word address shared by read and write (ADDR_W bits)
//   ram_write_data  write data (DATA_W bits)
//   byte_en         write byte lanes, bit k enables bits [8k+7:8k]
// Responses (slave -> master):
//   ram_out         registered read data
//   ram_valid       one-cycle pulse marking ram_out/addr_err valid
//   busy            high while the memory initialises itself
//   addr_err        out-of-range read flag, qualified by ram_valid
interface data_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  read_ram;
  logic                  write_ram;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_write_data;
  logic [DATA_W/8-1:0]   byte_en;
  logic [DATA_W-1:0]     ram_out;
  logic                  ram_valid;
  logic                  busy;
  logic                  addr_err;

  // The requester side drives requests and observes responses.
  modport master (
    output read_ram, write_ram, ram_addr, ram_write_data, byte_en,
    input  ram_out, ram_valid, busy, addr_err
  );

  // The memory side observes requests and drives responses.
  modport slave (
    input  read_ram, write_ram, ram_addr, ram_write_data, byte_en,
    output ram_out, ram_valid, busy, addr_err
  );
endinterface

// File: rtl/data_mem.sv
// data_mem
// Word-addressed data memory with byte-lane writes and a registered
// one-cycle read. After reset it spends DEPTH cycles writing word i with
// the value i, and it ignores all requests while doing so.
//
// Ports:
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    data_mem_if.slave carrying requests and responses
//
// Parameters:
//   DATA_W  data word width, multiple of 8 (default 32)
//   DEPTH   number of words, at least 2 (default 16)
//   ADDR_W  word address width (default 32)
//
// Optional feature macro: DATA_MEM_BYPASS_EN
//   Defined:   a read and write in the same cycle (they always share the
//              address) return the merged new word.
//   Undefined: the same case returns the pre-write word.
//   The array update is identical in both builds.
module data_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 32
) (
  input logic      clk,
  input logic      reset,
  data_mem_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANES = DATA_W / 8;

  typedef enum logic {
    INIT,
    READY
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   initCount_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  ramOut_q;
  logic               ramValid_q;
  logic               addrErr_q;

  logic               inRange;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  oldWord;
  logic [DATA_W-1:0]  mergedWord;
  logic [DATA_W-1:0]  ramOut_d;

  // Decode the shared address against the full address width so that
  // large addresses never alias into the array, then build the word a
  // write would leave behind (enabled lanes new, others old) and pick
  // the value a read returns this cycle.
  always_comb begin
    inRange    = (bus.ram_addr < ADDR_W'(DEPTH));
    idx        = bus.ram_addr[IDX_W-1:0];
    oldWord    = mem_q[idx];
    mergedWord = oldWord;
    for (int k = 0; k < LANES; k++) begin
      if (bus.byte_en[k]) begin
        mergedWord[8*k +: 8] = bus.ram_write_data[8*k +: 8];
      end
    end
    ramOut_d = '0;
    if (inRange) begin
`ifdef DATA_MEM_BYPASS_EN
      ramOut_d = bus.write_ram ? mergedWord : oldWord;
`else
      ramOut_d = oldWord;
`endif
    end
  end

  // Storage array. During INIT the counter walks the words and writes its
  // own value into each; in READY only in-range writes touch the array.
  // The array itself has no reset because INIT rewrites every word.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[initCount_q] <= DATA_W'(initCount_q);
    end else if (bus.write_ram && inRange) begin
      mem_q[idx] <= mergedWord;
    end
  end

  // Control FSM and registered read response. INIT moves to READY on the
  // edge that writes the last word, so busy lasts exactly DEPTH cycles.
  // Requests seen in INIT are dropped, not queued. A read in READY always
  // produces a response one cycle later, flagged if out of range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      initCount_q <= '0;
      ramOut_q    <= '0;
      ramValid_q  <= 1'b0;
      addrErr_q   <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          ramValid_q <= 1'b0;
          addrErr_q  <= 1'b0;
          if (initCount_q == IDX_W'(DEPTH - 1)) begin
            state_q     <= READY;
            initCount_q <= '0;
          end else begin
            initCount_q <= initCount_q + IDX_W'(1);
          end
        end
        READY: begin
          ramValid_q <= bus.read_ram;
          addrErr_q  <= bus.read_ram && !inRange;
          if (bus.read_ram) begin
            ramOut_q <= ramOut_d;
          end
        end
        default: begin
          state_q <= INIT;
        end
      endcase
    end
  end

  // Busy follows the state register directly, so reset raises it at once.
  assign bus.busy      = (state_q == INIT);
  assign bus.ram_out   = ramOut_q;
  assign bus.ram_valid = ramValid_q;
  assign bus.addr_err  = addrErr_q;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem
// Self-checking bench for data_mem: a behavioural memory model checked
// every cycle, plus directed transactions with literal expectations.
// A second instance with DEPTH=8 checks the shorter initialisation.
module tb_data_mem;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
`ifdef DATA_MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  data_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus  ();
  data_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus8 ();

  data_mem #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  data_mem #(.DATA_W(DW), .DEPTH(8), .ADDR_W(AW)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  // Model state: the word contents, how many init cycles remain, and
  // the response the memory should currently present.
  logic [DW-1:0] mMem [DEPTH];
  int            mInitLeft;
  logic [DW-1:0] mOut;
  logic          mValid;
  logic          mErr;

  function automatic logic [DW-1:0] mergeLanes(input logic [DW-1:0] old,
                                               input logic [DW-1:0] data,
                                               input logic [DW/8-1:0] be);
    logic [DW-1:0] w;
    w = old;
    for (int k = 0; k < DW/8; k++) if (be[k]) w[8*k +: 8] = data[8*k +: 8];
    return w;
  endfunction

  // Behavioural model: a plain array, an init countdown, and the rule
  // that a ready-state read is answered on the following cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mInitLeft <= DEPTH;
      mOut      <= '0;
      mValid    <= 1'b0;
      mErr      <= 1'b0;
    end else if (mInitLeft > 0) begin
      mMem[4'(DEPTH - mInitLeft)] <= DW'(DEPTH - mInitLeft);
      mInitLeft <= mInitLeft - 1;
      mValid    <= 1'b0;
      mErr      <= 1'b0;
    end else begin
      mValid <= bus.read_ram;
      mErr   <= bus.read_ram && (bus.ram_addr >= 32'(DEPTH));
      if (bus.write_ram && bus.ram_addr < 32'(DEPTH))
        mMem[bus.ram_addr[3:0]] <= mergeLanes(mMem[bus.ram_addr[3:0]],
                                              bus.ram_write_data, bus.byte_en);
      if (bus.read_ram) begin
        if (bus.ram_addr >= 32'(DEPTH))
          mOut <= '0;
        else if (BYP && bus.write_ram)
          mOut <= mergeLanes(mMem[bus.ram_addr[3:0]],
                             bus.ram_write_data, bus.byte_en);
        else
          mOut <= mMem[bus.ram_addr[3:0]];
      end
    end
  end

  // Every-cycle comparison of the main instance against the model,
  // sampled on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model_busy",  64'(bus.busy),      64'(mInitLeft > 0));
      checkOutput("model_valid", 64'(bus.ram_valid), 64'(mValid));
      checkOutput("model_err",   64'(bus.addr_err),  64'(mErr));
      checkOutput("model_out",   64'(bus.ram_out),   64'(mOut));
    end
  end

  // One cycle of stimulus on the main instance, applied just after a
  // rising edge so it is stable for the next one.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [AW-1:0] addr,
                               input logic [DW-1:0] data,
                               input logic [DW/8-1:0] be);
    @(posedge clk);
    #2;
    bus.read_ram       = rd;
    bus.write_ram      = wr;
    bus.ram_addr       = addr;
    bus.ram_write_data = data;
    bus.byte_en        = be;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
  endtask

  // Read one word from the DEPTH=8 instance and return its response.
  task automatic read8(input logic [AW-1:0] addr, output logic [DW-1:0] out,
                       output logic valid, output logic err);
    @(posedge clk);
    #2;
    bus8.read_ram = 1'b1;
    bus8.ram_addr = addr;
    @(posedge clk);
    #2;
    bus8.read_ram = 1'b0;
    out   = bus8.ram_out;
    valid = bus8.ram_valid;
    err   = bus8.addr_err;
  endtask

  // Count falling edges with busy high on each instance, bounded.
  task automatic countBusy(output int n16, output int n8);
    n16 = 0;
    n8  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.busy)  n16++;
      if (bus8.busy) n8++;
      if (!bus.busy && !bus8.busy) break;
    end
  endtask

  int            n16, n8;
  logic [DW-1:0] r8Out;
  logic          r8Valid, r8Err;

  initial begin
    bus.read_ram  = 0; bus.write_ram  = 0; bus.ram_addr  = '0;
    bus.ram_write_data = '0; bus.byte_en = '0;
    bus8.read_ram = 0; bus8.write_ram = 0; bus8.ram_addr = '0;
    bus8.ram_write_data = '0; bus8.byte_en = '0;

    repeat (3) @(posedge clk);
    #2;
    checkEn = 1'b1;
    checkOutput("reset_out",   64'(bus.ram_out),   64'h0);
    checkOutput("reset_valid", 64'(bus.ram_valid), 64'h0);
    checkOutput("reset_err",   64'(bus.addr_err),  64'h0);
    checkOutput("reset_busy",  64'(bus.busy),      64'h1);

    reset = 1'b0;
    countBusy(n16, n8);
    checkOutput("busy_cycles",    64'(n16), 64'd16);
    checkOutput("busy_cycles_d8", 64'(n8),  64'd8);

    applyStimulus(1, 0, 5, '0, '0);
    idle();
    checkOutput("rd5_out",   64'(bus.ram_out),   64'd5);
    checkOutput("rd5_valid", 64'(bus.ram_valid), 64'd1);
    idle();
    checkOutput("valid_pulse", 64'(bus.ram_valid), 64'd0);
    checkOutput("out_hold",    64'(bus.ram_out),   64'd5);

    read8(7, r8Out, r8Valid, r8Err);
    checkOutput("d8_rd7", 64'({r8Valid, r8Err, r8Out}), {31'd0, 1'b1, 1'b0, 32'd7});
    read8(8, r8Out, r8Valid, r8Err);
    checkOutput("d8_rd8", 64'({r8Valid, r8Err, r8Out}), {31'd0, 1'b1, 1'b1, 32'd0});

    applyStimulus(0, 1, 3, 32'hAABBCCDD, 4'b0101);
    applyStimulus(1, 0, 3, '0, '0);
    idle();
    checkOutput("lane_write", 64'(bus.ram_out), 64'h00BB00DD);

    applyStimulus(0, 1, 4, 32'hFFFFFFFF, 4'b0000);
    applyStimulus(1, 0, 4, '0, '0);
    idle();
    checkOutput("be_zero", 64'(bus.ram_out), 64'd4);

    applyStimulus(1, 0, 16, '0, '0);
    idle();
    checkOutput("rd16_out",   64'(bus.ram_out),   64'd0);
    checkOutput("rd16_err",   64'(bus.addr_err),  64'd1);
    checkOutput("rd16_valid", 64'(bus.ram_valid), 64'd1);
    idle();
    checkOutput("err_clear", 64'(bus.addr_err), 64'd0);

    applyStimulus(1, 0, 32'h0001_0005, '0, '0);
    idle();
    checkOutput("wide_addr_err", 64'({bus.addr_err, bus.ram_out}), {31'd0, 1'b1, 32'd0});

    applyStimulus(0, 1, 20, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, 0, AW'(i), '0, '0);
      if (i > 0)
        checkOutput("readback", 64'(bus.ram_out),
                    (i - 1 == 3) ? 64'h00BB00DD : 64'(i - 1));
    end
    idle();
    checkOutput("readback_last", 64'(bus.ram_out), 64'd15);

    applyStimulus(1, 1, 7, 32'h12345678, 4'hF);
    idle();
    checkOutput("same_cycle_rw", 64'(bus.ram_out),
                BYP ? 64'h12345678 : 64'h00000007);
    applyStimulus(1, 0, 7, '0, '0);
    idle();
    checkOutput("after_rw", 64'(bus.ram_out), 64'h12345678);

    applyStimulus(1, 1, 3, 32'h11223344, 4'b1010);
    idle();
    checkOutput("same_cycle_partial", 64'(bus.ram_out),
                BYP ? 64'h11BB33DD : 64'h00BB00DD);

    applyStimulus(0, 1, 9, 32'hDEADBEEF, 4'hF);
    idle();

    @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    applyStimulus(1, 0, 2, '0, '0);
    applyStimulus(0, 1, 9, 32'hFFFFFFFF, 4'hF);
    checkOutput("init_read_dropped", 64'(bus.ram_valid), 64'd0);
    repeat (5) idle();
    checkOutput("mid_init_busy", 64'(bus.busy), 64'd1);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    countBusy(n16, n8);
    checkOutput("busy_after_rst",    64'(n16), 64'd16);
    checkOutput("busy_after_rst_d8", 64'(n8),  64'd8);

    applyStimulus(1, 0, 9, '0, '0);
    idle();
    checkOutput("reinit_rd9", 64'(bus.ram_out), 64'd9);
    applyStimulus(1, 0, 7, '0, '0);
    idle();
    checkOutput("reinit_rd7", 64'(bus.ram_out), 64'd7);
    idle();

    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
